// File: rtl/sram_rgb_reader.sv
// Frame-buffer read side: RGB panel timing plus one SRAM read per active pixel, output RD_LAT+1 clocks after the counters.
// Optional TEST_PATTERN_EN adds Pattern_En, which replaces pixel data with an h/v gradient.
module sram_rgb_reader #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 2
) (
  input  logic              Sys_Clock,
  input  logic              Reset,
  input  logic              Frame_Ready,
`ifdef TEST_PATTERN_EN
  input  logic              Pattern_En,
`endif
  input  logic [23:0]       Sram_Data,
  output logic              Sram_RE,
  output logic [ADDR_W-1:0] Sram_Addr,
  output logic              RGB_HS_Inv,
  output logic              RGB_VS_Inv,
  output logic              RGB_DE,
  output logic [7:0]        RGB_R,
  output logic [7:0]        RGB_G,
  output logic [7:0]        RGB_B,
  output logic              Frame_Start
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [11:0]       h_cnt;
  logic [11:0]       v_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  logic run, act, hs, vs, fs;

  assign run = (state == RUN);
  assign act = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs  = run && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign vs  = run && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  assign fs  = run && (h_cnt == '0) && (v_cnt == '0);

  assign Sram_RE   = act;
  assign Sram_Addr = addr_cnt;

  always_ff @(posedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt    <= '0;
          v_cnt    <= '0;
          addr_cnt <= '0;
          if (Frame_Ready) state <= RUN;
        end
        RUN: begin
          // Address saturates on the last pixel so it never wraps inside a frame
          if (act && (addr_cnt != ADDR_LAST)) addr_cnt <= addr_cnt + ADDR_W'(1);
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt    <= '0;
              addr_cnt <= '0;
              if (!Frame_Ready) state <= IDLE;
            end else begin
              v_cnt <= v_cnt + 12'd1;
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RD_LAT stages here plus the output register give RD_LAT+1 total delay
  logic [RD_LAT-1:0] act_p, hs_p, vs_p, fs_p;
`ifdef TEST_PATTERN_EN
  logic [7:0] h_p [RD_LAT];
  logic [7:0] v_p [RD_LAT];
`endif

  always_ff @(posedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      act_p <= '0;
      hs_p  <= '0;
      vs_p  <= '0;
      fs_p  <= '0;
`ifdef TEST_PATTERN_EN
      for (int i = 0; i < RD_LAT; i++) begin
        h_p[i] <= '0;
        v_p[i] <= '0;
      end
`endif
    end else begin
      act_p[0] <= act;
      hs_p[0]  <= hs;
      vs_p[0]  <= vs;
      fs_p[0]  <= fs;
`ifdef TEST_PATTERN_EN
      h_p[0] <= h_cnt[7:0];
      v_p[0] <= v_cnt[7:0];
`endif
      for (int i = 1; i < RD_LAT; i++) begin
        act_p[i] <= act_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        fs_p[i]  <= fs_p[i-1];
`ifdef TEST_PATTERN_EN
        h_p[i] <= h_p[i-1];
        v_p[i] <= v_p[i-1];
`endif
      end
    end
  end

  always_ff @(posedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      RGB_DE      <= 1'b0;
      RGB_HS_Inv  <= 1'b1;
      RGB_VS_Inv  <= 1'b1;
      Frame_Start <= 1'b0;
      RGB_R       <= '0;
      RGB_G       <= '0;
      RGB_B       <= '0;
    end else begin
      RGB_DE      <= act_p[RD_LAT-1];
      RGB_HS_Inv  <= ~hs_p[RD_LAT-1];
      RGB_VS_Inv  <= ~vs_p[RD_LAT-1];
      Frame_Start <= fs_p[RD_LAT-1];
      if (!act_p[RD_LAT-1]) begin
        RGB_R <= '0;
        RGB_G <= '0;
        RGB_B <= '0;
`ifdef TEST_PATTERN_EN
      end else if (Pattern_En) begin
        RGB_R <= h_p[RD_LAT-1];
        RGB_G <= v_p[RD_LAT-1];
        RGB_B <= '0;
`endif
      end else begin
        // Sram_Data is valid in this cycle, so this is its single register stage
        RGB_R <= Sram_Data[7:0];
        RGB_G <= Sram_Data[15:8];
        RGB_B <= Sram_Data[23:16];
      end
    end
  end

endmodule

// File: tb/tb_sram_rgb_reader.sv
// Random Frame_Ready/reset stimulus against a frame-position reference model with an SRAM echo model.
module tb_sram_rgb_reader;

  localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int RD_LAT = 2;
  localparam int AW = 19;

  logic          Sys_Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Frame_Ready = 1'b1;
  logic          Pattern_En = 1'b0;
  logic [23:0]   Sram_Data = '0;
  logic          Sram_RE;
  logic [AW-1:0] Sram_Addr;
  logic          RGB_HS_Inv, RGB_VS_Inv, RGB_DE, Frame_Start;
  logic [7:0]    RGB_R, RGB_G, RGB_B;

  sram_rgb_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .ADDR_W(AW), .RD_LAT(RD_LAT)
  ) dut (
    .Sys_Clock(Sys_Clock),
    .Reset(Reset),
    .Frame_Ready(Frame_Ready),
`ifdef TEST_PATTERN_EN
    .Pattern_En(Pattern_En),
`endif
    .Sram_Data(Sram_Data),
    .Sram_RE(Sram_RE),
    .Sram_Addr(Sram_Addr),
    .RGB_HS_Inv(RGB_HS_Inv),
    .RGB_VS_Inv(RGB_VS_Inv),
    .RGB_DE(RGB_DE),
    .RGB_R(RGB_R),
    .RGB_G(RGB_G),
    .RGB_B(RGB_B),
    .Frame_Start(Frame_Start)
  );

  always #5 Sys_Clock = ~Sys_Clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit de, hs, vs, fs;
    int h, v, a;
  } ent_t;

  // Reference model: frame position n within an H_TOTAL*V_TOTAL cycle frame
  bit   running = 0;
  int   n = 0;
  ent_t q[$];

  bit        re_hist [8];
  bit [7:0]  ad_hist [8];
  int        cyc = 8;
  bit        last_re;

  function automatic ent_t cur_ent();
    ent_t e;
    e.h  = n % HT;
    e.v  = n / HT;
    e.de = running && (e.h < HA) && (e.v < VA);
    e.hs = running && (e.h >= HA + HFP) && (e.h < HA + HFP + HSY);
    e.vs = running && (e.v >= VA + VFP) && (e.v < VA + VFP + VSY);
    e.fs = running && (n == 0);
    e.a  = e.v * HA + e.h;
    return e;
  endfunction

  task automatic model_reset();
    ent_t idle;
    idle = '{de: 0, hs: 0, vs: 0, fs: 0, h: 0, v: 0, a: 0};
    running = 0;
    n = 0;
    q.delete();
    for (int i = 0; i <= RD_LAT; i++) q.push_back(idle);
  endtask

  task automatic model_edge(input bit fr);
    if (!running) begin
      if (fr) begin
        running = 1;
        n = 0;
      end
    end else if (n == HT * VT - 1) begin
      n = 0;
      if (!fr) running = 0;
    end else begin
      n++;
    end
  endtask

  // One clock: check mid-cycle, serve SRAM, then set inputs for the next edge
  task automatic tick(input bit fr, input bit rst);
    ent_t e, c;
    int   slot;
    @(negedge Sys_Clock);
    re_hist[cyc % 8] = Sram_RE;
    ad_hist[cyc % 8] = Sram_Addr[7:0];
    last_re = Sram_RE;
    slot = (cyc - RD_LAT) % 8;
    if (re_hist[slot]) Sram_Data = {ad_hist[slot], ad_hist[slot], ad_hist[slot]};
    else               Sram_Data = 24'($urandom);
    cyc++;

    c = cur_ent();
    e = q[0];
    check("sram_re", Sram_RE, c.de);
    if (c.de) check("sram_addr", Sram_Addr, c.a);
    check("de", RGB_DE, e.de);
    check("hs_inv", RGB_HS_Inv, !e.hs);
    check("vs_inv", RGB_VS_Inv, !e.vs);
    check("frame_start", Frame_Start, e.fs);
    if (!e.de) begin
      check("blank_rgb", {RGB_B, RGB_G, RGB_R}, 24'h0);
    end else if (Pattern_En) begin
      check("pat_r", RGB_R, e.h & 255);
      check("pat_g", RGB_G, e.v & 255);
      check("pat_b", RGB_B, 0);
    end else begin
      check("rgb_r", RGB_R, e.a & 255);
      check("rgb_g", RGB_G, e.a & 255);
      check("rgb_b", RGB_B, e.a & 255);
    end
    void'(q.pop_front());
    q.push_back(c);

    Frame_Ready = fr;
    Reset = rst;
    if (rst) model_reset();
    else     model_edge(fr);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_re"}, Sram_RE, 0);
    check({tag, "_addr"}, Sram_Addr, 0);
    check({tag, "_hs"}, RGB_HS_Inv, 1);
    check({tag, "_vs"}, RGB_VS_Inv, 1);
    check({tag, "_de"}, RGB_DE, 0);
    check({tag, "_rgb"}, {RGB_B, RGB_G, RGB_R}, 0);
    check({tag, "_fs"}, Frame_Start, 0);
  endtask

  initial begin
    int cnt;
    int guard;
    model_reset();

    // Reset held with Frame_Ready high
    repeat (4) tick(1, 1);
    check_reset_vals("rst_hold");

    // Release, then count reads over exactly one frame
    tick(1, 0);
    cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick(1, 0);
      if (last_re) cnt++;
    end
    check("reads_per_frame", cnt, HA * VA);
    repeat (HT * VT) tick(1, 0);

    // Drop Frame_Ready on line 1; frame must finish then idle
    guard = 0;
    while (!(running && n == HT) && guard < 200) begin
      tick(1, 0);
      guard++;
    end
    check("wait_line1_timeout", guard < 200, 1);
    cnt = 0;
    guard = 0;
    while (running && guard < 200) begin
      tick(0, 0);
      if (last_re) cnt++;
      guard++;
    end
    check("drain_timeout", guard < 200, 1);
    repeat (RD_LAT + 2) tick(0, 0);
    cnt = 0;
    repeat (10) begin
      tick(0, 0);
      if (last_re) cnt++;
    end
    check("idle_reads", cnt, 0);
    check("idle_hs", RGB_HS_Inv, 1);
    check("idle_vs", RGB_VS_Inv, 1);

    // Restart, then asynchronous reset at h=2, v=1
    repeat (HT * VT + 5) tick(1, 0);
    guard = 0;
    while (!(running && n == HT + 2) && guard < 200) begin
      tick(1, 0);
      guard++;
    end
    check("wait_h2v1_timeout", guard < 200, 1);
    tick(1, 1);
    #1;
    check_reset_vals("async_rst");
    repeat (3) tick(1, 1);
    tick(0, 0);
    cnt = 0;
    repeat (5) begin
      tick(0, 0);
      if (last_re) cnt++;
    end
    check("post_rst_no_read", cnt, 0);

    // Randomised Frame_Ready with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) tick(1, 1);
      else tick($urandom_range(0, 9) != 0, 0);
    end
    tick(1, 0);

`ifdef TEST_PATTERN_EN
    repeat (HT * VT) tick(1, 0);
    Pattern_En = 1'b1;
    repeat (2 * HT * VT) tick(1, 0);
    Pattern_En = 1'b0;
    repeat (HT * VT) tick(1, 0);
`endif

    repeat (HT * VT) tick(1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_rgb_reader.md
Name: sram_rgb_reader

Overview:
- Read side of the SRAM frame buffer. The DDT capture path fills the buffer; this block reads it out.
- Generates RGB panel timing (HS/VS/DE) from programmable H/V counters and issues one SRAM read per active pixel.
- Aligns returned SRAM data to the delayed timing signals and drives 24-bit RGB to the panel interface.
- Sits between the SRAM arbiter/read port and the RGB output pins, in the system clock domain.

Parameters:
- H_ACTIVE, 800: active pixels per line
- H_FP, 40: horizontal front porch, in clocks
- H_SYNC, 128: HS pulse width, in clocks
- H_BP, 88: horizontal back porch, in clocks
- V_ACTIVE, 600: active lines per frame
- V_FP, 1: vertical front porch, in lines
- V_SYNC, 4: VS pulse width, in lines
- V_BP, 23: vertical back porch, in lines
- ADDR_W, 19: SRAM word address width
- RD_LAT, 2: SRAM read latency, in clocks (legal range 1..4)

Ports:
- Sys_Clock  in  1  pixel/system clock; all logic on rising edge
- Reset  in  1  asynchronous reset, active-high
- Frame_Ready  in  1  level; buffer holds a complete frame (writer WE phase done)
- Sram_Data  in  24  read data {B[23:16],G[15:8],R[7:0]}, valid RD_LAT clocks after its Sram_RE cycle
- Sram_RE  out  1  read strobe, one per active pixel
- Sram_Addr  out  ADDR_W  read word address
- RGB_HS_Inv  out  1  horizontal sync, active-low
- RGB_VS_Inv  out  1  vertical sync, active-low
- RGB_DE  out  1  data enable
- RGB_R / RGB_G / RGB_B  out  8 each  pixel data
- Frame_Start  out  1  one-clock pulse, aligned with the first RGB_DE of each frame

Behaviour:
- Reset values: Sram_RE=0, Sram_Addr=0, RGB_HS_Inv=1, RGB_VS_Inv=1, RGB_DE=0, RGB_R/G/B=0, Frame_Start=0, state=IDLE, h_cnt=v_cnt=0, all delay pipes cleared. Reset asserted mid-frame takes effect immediately.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP. Counters are 12 bits.
- FSM:
  - IDLE: counters held at 0, no reads, syncs inactive. Frame_Ready=1 sampled at an edge → RUN; that edge leaves h_cnt=v_cnt=0.
  - RUN: h_cnt increments each clock and wraps at H_TOTAL-1 to 0; v_cnt increments on each h wrap and wraps at V_TOTAL-1 to 0.
  - Leaving RUN: at the clock where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, if Frame_Ready=0 → IDLE, otherwise stay in RUN. A frame in progress always completes; Frame_Ready dropping mid-frame is ignored until frame end.
- Counter-phase signals (combinational from registered counters, RUN only):
  - act = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Sram_RE=act in the same cycle.
- Sram_Addr equals the count of prior act cycles in the current frame, i.e. v*H_ACTIVE+h. It is cleared to 0 at h_cnt=0,v_cnt=0. Its last value is H_ACTIVE*V_ACTIVE-1, and it never wraps within a frame.
- Alignment:
  - act, hs, vs and a frame-start flag (h=0,v=0 in RUN) pass through an RD_LAT+1 stage shift register.
  - Sram_Data is registered once, in the cycle RD_LAT clocks after its Sram_RE cycle.
  - Outputs are therefore valid RD_LAT+1 clocks after the counter cycle: RGB_DE=act_d, RGB_HS_Inv=~hs_d, RGB_VS_Inv=~vs_d.
- RGB_R/G/B = Sram_Data fields when act is delayed-valid, otherwise forced to 0 (blanking is black).
- Returning to IDLE: the pipeline drains naturally with act=0 and syncs inactive.

Optional Feature:
- TEST_PATTERN_EN defined: adds input Pattern_En (1 bit).
  - When Pattern_En=1, RGB_R=h_cnt[7:0], RGB_G=v_cnt[7:0], RGB_B=8'h00, using the delayed counter values, during DE. Blanking is 0.
  - Sram_RE is still issued.
  - This allows panel bring-up without a written frame buffer.
- TEST_PATTERN_EN undefined: no Pattern_En port; RGB always comes from Sram_Data.

Test Plan (small params: H 4/1/2/1 → H_TOTAL=8; V 3/1/1/1 → V_TOTAL=6; RD_LAT=2; SRAM model returns {addr,addr,addr} low bytes):
- Reset held with Frame_Ready=1 → all outputs at reset values, Sram_RE=0. Release Reset → first Sram_RE=1 with Sram_Addr=0 in the first cycle after Frame_Ready is sampled.
- One full frame → 12 Sram_RE cycles at addresses 0..11 in order; RGB_DE has 3 bursts of 4 clocks; RGB_R = 0,1,2,3 / 4..7 / 8..11; first RGB_DE occurs 3 clocks after the first Sram_RE, with Frame_Start=1 in that same cycle only.
- Sync check → RGB_HS_Inv low for 2 clocks at h=5,6 (delayed by 3 clocks); RGB_VS_Inv low for exactly 8 clocks (line v=4); RGB_R/G/B=0 whenever RGB_DE=0.
- Drop Frame_Ready at v=1 → frame completes all 12 reads, then IDLE: no Sram_RE, syncs high. Raise Frame_Ready again → restart at Sram_Addr=0.
- Assert Reset at h=2,v=1 → outputs return to reset values asynchronously, with no further Sram_RE until Frame_Ready is sampled after release.
- With TEST_PATTERN_EN and Pattern_En=1 → during DE, RGB_R = h (0..3), RGB_G = v (0..2), RGB_B = 0, independent of Sram_Data.
